// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, oversampling constants and frame defaults
// used by both the 16x TX and 16x RX blocks.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int OS_RATE     = 16;
  localparam int MID_TICK    = 7;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage flip-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so idle-high lines come out of reset inactive.
module sync_2ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver (N data bits, LSB first, idle-high line) with a
// one-byte holding register, framing-error and overrun pulses.
//
// Handshake: rx_valid is a level meaning rx_data holds an unread byte; rx_rd
// clears it on the next clk. A read in the same clk as a good-frame completion
// is applied first, so the new byte loads and rx_valid stays high, no overrun.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DBIT        = DEF_DBIT,
  parameter int SB_TICK     = DEF_SB_TICK,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rx_rd,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  output logic            rx_busy,
  output logic            frame_err,
  output logic            overrun,
  output logic [1:0]      state_dbg
);

  localparam int TW = (SB_TICK > OS_RATE) ? $clog2(SB_TICK) : $clog2(OS_RATE);
  localparam int BW = $clog2(DBIT);
  localparam logic [TW-1:0] MID_T    = TW'(MID_TICK);
  localparam logic [TW-1:0] LAST_T   = TW'(OS_RATE - 1);
  localparam logic [TW-1:0] STOP_T   = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DBIT - 1);

  logic            rx_s;
  logic            rx_prev;
  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [DBIT-1:0] shift_reg;
  logic            fall;
  logic            start_hit;
  logic            bit_hit;
  logic            stop_hit;
  logic            good_done;
  logic            bad_done;
  logic            load;
  logic            ovr_hit;

  sync_2ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

  // A held-low line never re-triggers: only a genuine high-to-low transition starts a frame.
  assign fall      = rx_prev & ~rx_s;
  assign start_hit = s_tick && (tick_cnt == MID_T);
  assign bit_hit   = s_tick && (tick_cnt == LAST_T);
  assign stop_hit  = s_tick && (tick_cnt == STOP_T);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fall) state_next = START;
      START:   if (start_hit) state_next = rx_s ? IDLE : DATA;
      DATA:    if (bit_hit && (bit_cnt == LAST_BIT)) state_next = STOP;
      STOP:    if (stop_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_busy   = (state != IDLE);
    good_done = (state == STOP) && stop_hit && rx_s;
    bad_done  = (state == STOP) && stop_hit && !rx_s;
    load      = good_done && (!rx_valid || rx_rd);
    ovr_hit   = good_done && rx_valid && !rx_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) tick_cnt <= '0;
        end
        START: begin
          if (s_tick) tick_cnt <= start_hit ? '0 : tick_cnt + 1'b1;
          if (start_hit) bit_cnt <= '0;
        end
        DATA: begin
          if (bit_hit) begin
            tick_cnt  <= '0;
            shift_reg <= {rx_s, shift_reg[DBIT-1:1]};
            if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (s_tick) tick_cnt <= stop_hit ? '0 : tick_cnt + 1'b1;
        end
        default: tick_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_done;
      overrun   <= ovr_hit;
      if (load) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_rd) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: a serial-line driver, a frame-level reference model that
// predicts load/overrun/frame-error events, and a monitor popping those predictions.
module tb_uart_rx_os16;

  localparam logic [1:0] K_LOAD = 2'd0;
  localparam logic [1:0] K_OVR  = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic [1:0] state_dbg;

  logic       mon_rd = 1'b0;
  logic       man_rd = 1'b0;
  assign rx_rd = mon_rd | man_rd;

  int checks = 0;
  int errors = 0;
  int tick_per = 4;
  int tick_div = 0;
  int tick_n = 0;
  int cur_tick = 0;
  int start_tick = 0;
  int last_load_tick = -1;
  bit auto_read = 1'b0;
  bit model_valid = 1'b0;
  logic valid_prev = 1'b0;
  logic [9:0] exp_q[$];

  uart_rx_os16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tick    (s_tick),
    .rx        (rx),
    .rx_rd     (rx_rd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Baud tick source: s_tick is high for one clk every tick_per clks.
  always @(posedge clk) begin
    #1;
    if (tick_div >= tick_per - 1) begin
      tick_div = 0;
      s_tick = 1'b1;
      tick_n++;
    end else begin
      tick_div++;
      s_tick = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_evt(input logic [1:0] kind, input logic [7:0] data, input string nm);
    logic [9:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got kind %0d data %0h expected no event", nm, kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e !== {kind, data}) begin
        errors++;
        $display("FAIL event_%s: got kind %0d data %0h expected kind %0d data %0h",
                 nm, kind, data, e[9:8], e[7:0]);
      end
    end
  endtask

  // Monitor: every DUT event must match the next prediction in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_prev = 1'b0;
      mon_rd = 1'b0;
    end else begin
      if (frame_err) expect_evt(K_ERR, 8'h00, "frame_err");
      if (overrun) expect_evt(K_OVR, 8'h00, "overrun");
      if (rx_valid && !valid_prev) begin
        last_load_tick = tick_n;
        expect_evt(K_LOAD, rx_data, "load");
        if (auto_read) begin
          mon_rd = 1'b1;
          model_valid = 1'b0;
        end
      end else begin
        mon_rd = 1'b0;
      end
      valid_prev = rx_valid;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk iff s_tick);
      cur_tick = tick_n;
      #1;
    end
  endtask

  task automatic man_read();
    @(negedge clk);
    man_rd = 1'b1;
    @(negedge clk);
    man_rd = 1'b0;
    model_valid = 1'b0;
  endtask

  // Reference model: predicts the frame outcome from the holding-register rules,
  // then drives the 10-bit frame at 16 ticks per bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit rd_at_stop);
    int n;
    if (!stop_bit) begin
      exp_q.push_back({K_ERR, 8'h00});
    end else if (!model_valid) begin
      exp_q.push_back({K_LOAD, d});
      model_valid = 1'b1;
    end else if (!rd_at_stop) begin
      exp_q.push_back({K_OVR, 8'h00});
    end
    wait_ticks(1);
    start_tick = cur_tick;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stop_bit;
    if (rd_at_stop) begin
      wait_ticks(7);
      n = 0;
      do begin
        @(posedge clk);
        #2;
        n++;
      end while (!(s_tick && tick_n == start_tick + 152) && n < 40);
      check("rd_align", n < 40, 1);
      man_rd = 1'b1;
      @(posedge clk);
      #2;
      man_rd = 1'b0;
      wait_ticks(8);
    end else begin
      wait_ticks(16);
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] perm [256];
    logic [7:0] tmp;
    int j;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    wait_ticks(4);

    // Single 0xA5 frame, latency measured in ticks from start of the start bit.
    send_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    check("a5_latency", last_load_tick - start_tick, 152);
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid", rx_valid, 1);
    check("a5_busy", rx_busy, 0);
    man_read();
    @(negedge clk);
    check("a5_read_clears", rx_valid, 0);

    // False start: 3 ticks low, aborted at the mid-start sample.
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(1);
    check("glitch_busy", rx_busy, 1);
    wait_ticks(6);
    check("glitch_idle", rx_busy, 0);
    check("glitch_valid", rx_valid, 0);
    wait_ticks(8);
    send_frame(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    check("3c_data", rx_data, 8'h3C);
    man_read();

    // Framing error, then a break that must not start a frame.
    send_frame(8'h55, 1'b0, 1'b0);
    check("ferr_valid", rx_valid, 0);
    wait_ticks(40);
    check("break_busy", rx_busy, 0);
    check("break_state", state_dbg, 0);
    rx = 1'b1;
    wait_ticks(20);
    check("break_release_busy", rx_busy, 0);
    check("break_release_valid", rx_valid, 0);

    // Overrun: second byte dropped, first kept.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_valid", rx_valid, 1);
    man_read();
    // Read coincides with completion: new byte loads, no overrun.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    @(negedge clk);
    check("rdwin_data", rx_data, 8'h22);
    check("rdwin_valid", rx_valid, 1);
    man_read();

    // Reset in the middle of bit 4 of 0xF0 while a byte is held.
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) wait_ticks(16);
    rx = 1'b1;
    wait_ticks(8);
    @(negedge clk);
    check("pre_rst_busy", rx_busy, 1);
    check("pre_rst_valid", rx_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_state", state_dbg, 0);
    model_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(20);
    send_frame(8'h81, 1'b1, 1'b0);
    @(negedge clk);
    check("post_rst_data", rx_data, 8'h81);
    man_read();

    // Loopback of all byte values in random order with random idle gaps.
    auto_read = 1'b1;
    tick_per = 1;
    wait_ticks(20);
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      wait_ticks($urandom_range(0, 20));
      send_frame(perm[i], 1'b1, 1'b0);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    check("final_busy", rx_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
